hamming_scrubber_ext: RTL and testbench

HAMMING_SCRUBBER_EXT -- requirements
Module: hamming_scrubber_ext

---
 rtl/hamming_scrubber_ext.sv | 201 ++++++++++++++++++++
 tb/tb_hamming_scrubber_ext.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_scrubber_ext.sv
// hamming_scrubber_ext: walks a SECDED(8,4)-protected memory from address 0 to 2^ADDR_W-1,
// corrects single-bit errors by writing back a re-encoded codeword, and counts and logs
// uncorrectable words.
//
// Ports:
//   clk, rst          - clock; synchronous active-high reset
//   start, abort      - begin a pass (IDLE only); terminate the pass in progress
//   mem_gnt           - memory port granted to the scrubber this cycle
//   mem_rd_data       - codeword returned one cycle after mem_rd_en
//   mem_addr          - current word address (registered)
//   mem_rd_en         - read strobe (RD state, follows mem_gnt)
//   mem_wr_en         - write strobe (WR state, follows mem_gnt)
//   mem_wr_data       - re-encoded codeword for write-back
//   busy, done        - pass active; one-cycle pass-complete pulse
//   ce_count          - corrected-word count (saturating)
//   ue_count          - uncorrectable-word count (saturating)
//   ue_flag, ue_addr  - sticky uncorrectable flag and address of the first such word
`timescale 1ns/1ps
module hamming_scrubber_ext #(
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              mem_gnt,
   input  logic [7:0]        mem_rd_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   output logic              mem_wr_en,
   output logic [7:0]        mem_wr_data,
   output logic              busy,
   output logic              done,
   output logic [7:0]        ce_count,
   output logic [7:0]        ue_count,
   output logic              ue_flag,
   output logic [ADDR_W-1:0] ue_addr
);

   typedef enum logic [2:0] {StIdle, StRd, StEval, StWr, StAdv, StDone} state_e;

   state_e            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_addr, r_ue_addr;
   logic [7:0]        r_ce, r_ue, r_code;
   logic              r_ue_flag;

   logic [2:0]        w_syn;
   logic              w_glob;
   logic              w_ue;
   logic [7:0]        w_fixed;
   logic [7:0]        w_enc;
   logic              w_rewrite;
   logic              w_last;
   logic              w_abort_hit;

   // Codeword map: [0]=P1 [1]=P2 [2]=D1 [3]=P3 [4]=D2 [5]=D3 [6]=D4 [7]=P4.
   // d[0]=D1 .. d[3]=D4.
   function automatic logic [7:0] f_encode(input logic [3:0] d);
      logic [7:0] c;
      c    = '0;
      c[2] = d[0];
      c[4] = d[1];
      c[5] = d[2];
      c[6] = d[3];
      c[0] = d[0] ^ d[1] ^ d[3];
      c[1] = d[0] ^ d[2] ^ d[3];
      c[3] = d[1] ^ d[2] ^ d[3];
      c[7] = ^c[6:0];
      return c;
   endfunction

   // Decoder. Each syndrome bit re-checks one parity group; the syndrome value is the
   // 1-based position of a single flipped bit within [6:0].
   always_comb begin
      w_syn[0] = ^(mem_rd_data & 8'h55);
      w_syn[1] = ^(mem_rd_data & 8'h66);
      w_syn[2] = ^(mem_rd_data & 8'h78);
      w_glob   = ^mem_rd_data;
      w_ue     = (w_syn != 3'd0) && !w_glob;
      w_fixed  = mem_rd_data;
      if ((w_syn != 3'd0) && w_glob) begin
         w_fixed[w_syn - 3'd1] = ~mem_rd_data[w_syn - 3'd1];
      end
      w_enc     = f_encode({w_fixed[6], w_fixed[5], w_fixed[4], w_fixed[2]});
      // Also catches a lone P4 fault (syndrome 0, odd overall parity).
      w_rewrite = (w_enc != mem_rd_data);
   end

   assign w_last      = (r_addr == {ADDR_W{1'b1}});
   assign w_abort_hit = abort && (r_state != StIdle) && (r_state != StDone);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StIdle:  if (start) w_state_nxt = StRd;
         StRd:    if (mem_gnt) w_state_nxt = StEval;
         StEval: begin
            if (w_ue) begin
               w_state_nxt = StAdv;
            end else if (w_rewrite) begin
               w_state_nxt = StWr;
            end else begin
               w_state_nxt = StAdv;
            end
         end
         StWr:    if (mem_gnt) w_state_nxt = StAdv;
         StAdv:   w_state_nxt = w_last ? StDone : StRd;
         StDone:  w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
      if (w_abort_hit) begin
         w_state_nxt = StIdle;
      end
   end

   // Outputs decoded from state; strobes are suppressed while reset is applied.
   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      mem_rd_en = 1'b0;
      mem_wr_en = 1'b0;
      unique case (r_state)
         StRd: begin
            busy      = 1'b1;
            mem_rd_en = mem_gnt && !rst;
         end
         StEval: busy = 1'b1;
         StWr: begin
            busy      = 1'b1;
            mem_wr_en = mem_gnt && !rst;
         end
         StAdv:   busy = 1'b1;
         StDone:  done = 1'b1;
         default: ;
      endcase
   end

   // Datapath: address, counters, error log and write-back codeword.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr    <= '0;
         r_ce      <= '0;
         r_ue      <= '0;
         r_ue_flag <= 1'b0;
         r_ue_addr <= '0;
         r_code    <= '0;
      end else if (!w_abort_hit) begin
         unique case (r_state)
            StIdle: begin
               if (start) begin
                  r_addr    <= '0;
                  r_ce      <= '0;
                  r_ue      <= '0;
                  r_ue_flag <= 1'b0;
                  r_ue_addr <= '0;
               end
            end
            StEval: begin
               if (w_ue) begin
                  r_ue <= (r_ue == 8'hFF) ? r_ue : r_ue + 8'd1;
                  if (!r_ue_flag) begin
                     r_ue_flag <= 1'b1;
                     r_ue_addr <= r_addr;
                  end
               end else begin
                  r_code <= w_enc;
               end
            end
            StWr: begin
               if (mem_gnt) begin
                  r_ce <= (r_ce == 8'hFF) ? r_ce : r_ce + 8'd1;
               end
            end
            StAdv: begin
               if (!w_last) begin
                  r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_addr    = r_addr;
   assign mem_wr_data = r_code;
   assign ce_count    = r_ce;
   assign ue_count    = r_ue;
   assign ue_flag     = r_ue_flag;
   assign ue_addr     = r_ue_addr;

endmodule

// File: tb/tb_hamming_scrubber_ext.sv
// Bench for hamming_scrubber_ext: a 4-word pass instance for the functional cases and a
// 512-word instance for counter saturation. Expected write-backs are queued before each
// pass and popped by a monitor whenever the DUT issues a write.
`timescale 1ns/1ps
module tb_hamming_scrubber_ext;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, abort, gnt;
   logic [7:0] rd_data;
   logic [1:0] addr, ue_addr;
   logic       rd_en, wr_en, busy, done, ue_flag;
   logic [7:0] wr_data, ce, ue;

   logic       s_start, s_abort, s_gnt;
   logic [7:0] s_rd_data;
   logic [8:0] s_addr, s_ue_addr;
   logic       s_rd_en, s_wr_en, s_busy, s_done, s_ue_flag;
   logic [7:0] s_wr_data, s_ce, s_ue;

   hamming_scrubber_ext #(.ADDR_W(2)) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .mem_gnt(gnt),
      .mem_rd_data(rd_data), .mem_addr(addr), .mem_rd_en(rd_en), .mem_wr_en(wr_en),
      .mem_wr_data(wr_data), .busy(busy), .done(done), .ce_count(ce), .ue_count(ue),
      .ue_flag(ue_flag), .ue_addr(ue_addr)
   );

   hamming_scrubber_ext #(.ADDR_W(9)) u_sat (
      .clk(clk), .rst(rst), .start(s_start), .abort(s_abort), .mem_gnt(s_gnt),
      .mem_rd_data(s_rd_data), .mem_addr(s_addr), .mem_rd_en(s_rd_en), .mem_wr_en(s_wr_en),
      .mem_wr_data(s_wr_data), .busy(s_busy), .done(s_done), .ce_count(s_ce),
      .ue_count(s_ue), .ue_flag(s_ue_flag), .ue_addr(s_ue_addr)
   );

   logic [7:0]  mem [4];
   logic [15:0] exp_q [$];
   logic [15:0] mon_exp;
   bit          mon_en = 1'b0;
   int          total = 0;
   int          bad = 0;

   // Memory returns the addressed word one cycle after a granted read.
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Write-back scoreboard plus strobe exclusivity.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("rd_wr_excl", {31'd0, rd_en & wr_en}, 32'd0);
         if (wr_en === 1'b1) begin
            mon_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hFFFF;
            chk("wr_back", {16'd0, 6'd0, addr, wr_data}, {16'd0, mon_exp});
         end
      end
   end

   task automatic set_mem(input logic [7:0] w0, w1, w2, w3);
      mem[0] = w0; mem[1] = w1; mem[2] = w2; mem[3] = w3;
   endtask

   // Leaves the caller 1 time unit into cycle 1 (the cycle after the start edge).
   task automatic start_pass();
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int limit, output int cyc);
      cyc = -1;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            cyc = i;
            break;
         end
      end
   endtask

   int c, dn;

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0; gnt = 1'b1;
      s_start = 1'b0; s_abort = 1'b0; s_gnt = 1'b1; s_rd_data = 8'h01;
      rd_data = 8'h00;
      set_mem(8'h00, 8'h00, 8'h00, 8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_strobes", {30'd0, rd_en, wr_en}, 32'd0);
      chk("rst_regs", {6'd0, addr, ce, ue, wr_data}, 32'd0);
      chk("rst_ue_log", {29'd0, ue_flag, ue_addr}, 32'd0);
      rst = 1'b0;
      mon_en = 1'b1;

      // Clean pass: 4 words x 3 cycles, DONE visible in cycle 13.
      start_pass();
      wait_done(40, c);
      chk("clean_done_cyc", c, 13);
      chk("clean_counts", {16'd0, ce, ue}, 32'd0);
      @(negedge clk);
      chk("clean_done_pulse", {30'd0, done, busy}, 32'd0);
      chk("clean_q_empty", exp_q.size(), 0);

      // Two correctable words; a start mid-pass must not clear the counters.
      set_mem(8'h00, 8'h01, 8'hFB, 8'h00);
      exp_q.push_back({6'd0, 2'd1, 8'h00});
      exp_q.push_back({6'd0, 2'd2, 8'hFF});
      start_pass();
      repeat (8) @(negedge clk);
      chk("ce_mid_pass", {24'd0, ce}, 32'd1);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
      wait_done(40, c);
      chk("ce_done_cyc", c, 6);
      chk("ce_counts", {16'd0, ce, ue}, {16'd0, 8'd2, 8'd0});
      chk("ce_q_empty", exp_q.size(), 0);

      // Parity-bit-only fault is rewritten.
      set_mem(8'h80, 8'h00, 8'h00, 8'h00);
      exp_q.push_back({6'd0, 2'd0, 8'h00});
      start_pass();
      wait_done(40, c);
      chk("p4_done_cyc", c, 14);
      chk("p4_counts", {16'd0, ce, ue}, {16'd0, 8'd1, 8'd0});
      chk("p4_q_empty", exp_q.size(), 0);

      // Double errors: logged, never written.
      set_mem(8'h00, 8'h03, 8'h00, 8'h05);
      start_pass();
      wait_done(40, c);
      chk("ue_done_cyc", c, 13);
      chk("ue_counts", {16'd0, ce, ue}, {16'd0, 8'd0, 8'd2});
      chk("ue_log", {29'd0, ue_flag, ue_addr}, {29'd0, 1'b1, 2'd1});

      // Grant stalls: 5 cycles in RD (word 0) and 5 in WR (word 1) add 10 cycles.
      set_mem(8'h00, 8'h01, 8'h00, 8'h00);
      exp_q.push_back({6'd0, 2'd1, 8'h00});
      @(negedge clk) start = 1'b1;
      gnt = 1'b0;
      @(posedge clk);
      #1 start = 1'b0;
      c = -1;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         gnt = ((cyc >= 1 && cyc <= 5) || (cyc >= 11 && cyc <= 15)) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (cyc == 3) begin
            chk("stall_rd_strobe", {30'd0, rd_en, busy}, {30'd0, 1'b0, 1'b1});
            chk("stall_rd_addr", {30'd0, addr}, 32'd0);
         end
         if (cyc == 13) begin
            chk("stall_wr_strobe", {30'd0, wr_en, busy}, {30'd0, 1'b0, 1'b1});
            chk("stall_wr_addr", {30'd0, addr}, 32'd1);
         end
         if (cyc == 16) chk("stall_wr_go", {31'd0, wr_en}, 32'd1);
         if (done === 1'b1) begin
            c = cyc;
            break;
         end
         @(posedge clk);
         #1;
      end
      gnt = 1'b1;
      chk("stall_done_cyc", c, 24);
      chk("stall_counts", {16'd0, ce, ue}, {16'd0, 8'd1, 8'd0});
      chk("stall_q_empty", exp_q.size(), 0);

      // Abort while evaluating word 1 (cycle 5): idle next cycle, word-0 results held.
      set_mem(8'h03, 8'h03, 8'h00, 8'h00);
      start_pass();
      repeat (4) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      chk("abort_idle", {30'd0, busy, done}, 32'd0);
      chk("abort_counts", {16'd0, ce, ue}, {16'd0, 8'd0, 8'd1});
      chk("abort_log", {28'd0, ue_flag, ue_addr, 1'b0}, {28'd0, 1'b1, 2'd0, 1'b0});
      chk("abort_addr", {30'd0, addr}, 32'd1);
      dn = 0;
      repeat (20) @(negedge clk) dn += int'(done);
      chk("abort_no_done", dn, 0);

      // Reset during the word-1 write (cycle 7): no strobe, everything cleared.
      set_mem(8'hFB, 8'hFB, 8'h00, 8'h00);
      exp_q.push_back({6'd0, 2'd0, 8'hFF});
      start_pass();
      repeat (6) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("rst_wr_pre_ce", {24'd0, ce}, 32'd1);
      chk("rst_wr_no_strobe", {30'd0, rd_en, wr_en}, 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_wr_ctrl", {28'd0, busy, done, rd_en, wr_en}, 32'd0);
      chk("rst_wr_regs", {6'd0, addr, ce, ue, wr_data}, 32'd0);
      chk("rst_wr_log", {29'd0, ue_flag, ue_addr}, 32'd0);
      chk("rst_wr_q_empty", exp_q.size(), 0);

      // 512 correctable words in one pass: corrected count sticks at 255.
      @(negedge clk) s_start = 1'b1;
      @(negedge clk) s_start = 1'b0;
      c = -1;
      for (int i = 1; i <= 3000; i++) begin
         @(negedge clk);
         if (s_done === 1'b1) begin
            c = i;
            break;
         end
      end
      chk("sat_done_seen", {31'd0, c > 0}, 32'd1);
      chk("sat_ce", {24'd0, s_ce}, 32'd255);
      chk("sat_ue", {24'd0, s_ue}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
